scope_capture: RTL and testbench
================================

# scope_capture

Triggered capture buffer that consumes the 8-bit ADC sample stream (sample plus single-cycle valid strobe) produced by the ADC front end. It records samples into a circular on-chip RAM and detects a level-crossing trigger. It keeps a programmable number of pre-trigger samples, then fills the rest of the buffer. It then replays the whole record in chronological order over a ready/valid read port toward the host-link logic.

## Interface
Parameters:
- pDepth, 256, record length in samples; power of two.
- pAddrBits, 8, log2(pDepth).

Ports:
- iClk  in  1  system clock (100 MHz).
- iRst_n  in  1  reset. Asynchronous, active-low.
- iSample  in  8  ADC sample, unsigned.
- iSample_Valid  in  1  one-cycle strobe qualifying iSample.
- iArm  in  1  start-capture pulse. Honoured only in IDLE.
- iTrigLevel  in  8  trigger threshold, unsigned. Sampled at arm.
- iTrigRising  in  1  1 = rising edge, 0 = falling edge. Sampled at arm.
- iPreTrig  in  pAddrBits  pre-trigger sample count. Sampled at arm. Values > pDepth-1 clamp to pDepth-1.
- iRd_Ready  in  1  consumer ready.
- oRd_Data  out  8  readout sample.
- oRd_Valid  out  1  readout data valid.
- oBusy  out  1  high in PREFILL, WAIT_TRIG and POST.
- oTriggered  out  1  high from the trigger until return to IDLE.

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, POST, READOUT.
- IDLE:
  - iArm latches the config, clears counters and the prev-sample-valid flag.
  - Goes to PREFILL, or to WAIT_TRIG if the latched pre-trigger count = 0.
- Sample writes: every valid sample in PREFILL, WAIT_TRIG or POST is written at wr_addr. wr_addr then increments modulo pDepth.
- PREFILL: counts writes. After the pre-trigger count is reached, goes to WAIT_TRIG. Trigger conditions here are ignored.
- WAIT_TRIG: writes continue, wrapping and overwriting the oldest data.
- Trigger detection:
  - Rising: prev < level && cur >= level.
  - Falling: prev >= level && cur < level.
  - prev is the last valid sample since arm, including samples taken during PREFILL. No trigger is possible until one prior sample exists.
- On trigger:
  - The triggering sample is written.
  - trig_addr = its address.
  - The post counter is loaded with pDepth - pretrig - 1.
  - State goes to POST, or straight to READOUT if the count is 0.
- POST: each write decrements the counter. Reaching 0 goes to READOUT.
- READOUT:
  - Read start = (trig_addr - pretrig) mod pDepth. Exactly pDepth words are emitted, addresses incrementing mod pDepth.
  - Word index pretrig is the trigger sample.
  - After the last word is accepted, state returns to IDLE.
- Samples arriving in READOUT or IDLE are discarded. iArm outside IDLE is ignored.
- Handshake rules:
  - A word transfers when oRd_Valid && iRd_Ready.
  - oRd_Data and oRd_Valid stay stable while oRd_Valid && !iRd_Ready.
  - No word is lost or duplicated.
- Arithmetic: all address math is unsigned pAddrBits, wrapping. Comparisons are unsigned 8-bit.

## Timing
- Reset values: all outputs 0. State is IDLE; counters, addresses and prev flag are cleared. Reset takes effect asynchronously; release is synchronised internally (two-flop).
- Reset mid-operation aborts the record. RAM contents are don't-care.
- oBusy rises the cycle after iArm is seen in IDLE.
- oTriggered rises the cycle after the trigger sample's valid cycle.
- RAM read has 1-cycle registered latency. The first oRd_Valid appears no later than 3 cycles after entering READOUT.
- With iRd_Ready held high, throughput is one word per cycle. This requires a 2-entry output buffer to absorb RAM latency under back-pressure.
- oBusy falls on entry to READOUT. oTriggered falls on the cycle returning to IDLE.
- Simultaneous events:
  - A sample valid in the same cycle PREFILL completes is the last prefill sample.
  - The trigger is evaluated from the next sample onward.

## Structure
- Shared package scope_pkg holds:
  - the state enum type;
  - SAMPLE_W = 8;
  - the trigger-edge encoding constants.
- Sub-module scope_capture_ram: simple dual-port pDepth x 8, one write port, registered read port. Written to infer iCE40 EBR.
- Control FSM, trigger comparator and output skid buffer live in scope_capture.

## Test plan
- Ramp 0..255 repeating, pretrig 64, level 128, rising -> 256 words out: word 0 = 64, word 64 = 128, each word = previous + 1 mod 256.
- Same ramp, pretrig 0 -> word 0 = 128 (trigger sample). Exactly 256 words, then IDLE with oTriggered = 0.
- Descending ramp, level 100, falling -> word at index pretrig = 99. Preceding word = 100.
- Random iRd_Ready (50%) during readout -> 256 unique in-order words. Data stable whenever valid && !ready. Scoreboard matches.
- Crossing of 128 within first 10 samples with pretrig 64 -> ignored. Trigger occurs on next crossing after PREFILL.
- iRst_n low during POST -> all outputs 0 immediately. A fresh iArm after release produces a correct full record.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types and constants for the triggered scope capture block.
package scope_pkg;

  localparam int unsigned SAMPLE_W = 8;

  // Trigger edge selection as latched from iTrigRising.
  localparam logic EDGE_FALLING = 1'b0;
  localparam logic EDGE_RISING  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_WAIT_TRIG,
    ST_POST,
    ST_READOUT
  } state_t;

  // Level-crossing test between the previous and current sample.
  function automatic logic level_cross(
    input logic [SAMPLE_W-1:0] prev,
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] level,
    input logic                edge_sel
  );
    if (edge_sel == EDGE_RISING) return (prev < level) && (cur >= level);
    else                         return (prev >= level) && (cur < level);
  endfunction

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module scope_capture_ram
  import scope_pkg::*;
#(
  parameter int unsigned pDepth    = 256,
  parameter int unsigned pAddrBits = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [pAddrBits-1:0] wr_addr,
  input  logic [SAMPLE_W-1:0]  wr_data,
  input  logic                 rd_en,
  input  logic [pAddrBits-1:0] rd_addr,
  output logic [SAMPLE_W-1:0]  rd_data
);

  logic [SAMPLE_W-1:0] mem [pDepth];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_capture.sv
// Triggered capture buffer: circular recording, level-crossing trigger,
// chronological replay over a ready/valid port.
module scope_capture
  import scope_pkg::*;
#(
  parameter int unsigned pDepth    = 256,
  parameter int unsigned pAddrBits = 8
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [SAMPLE_W-1:0]  iSample,
  input  logic                 iSample_Valid,
  input  logic                 iArm,
  input  logic [SAMPLE_W-1:0]  iTrigLevel,
  input  logic                 iTrigRising,
  input  logic [pAddrBits-1:0] iPreTrig,
  input  logic                 iRd_Ready,
  output logic [SAMPLE_W-1:0]  oRd_Data,
  output logic                 oRd_Valid,
  output logic                 oBusy,
  output logic                 oTriggered
);

  localparam logic [pAddrBits:0]   WORDS   = (pAddrBits+1)'(pDepth);
  localparam logic [pAddrBits-1:0] PRE_MAX = pAddrBits'(pDepth - 1);

  logic rst_meta, rst_sync;

  state_t state, state_next;

  logic [SAMPLE_W-1:0]  level, prev;
  logic                 rising_sel, prev_valid, triggered;
  logic [pAddrBits-1:0] pretrig, wr_addr, cnt, trig_addr, rd_addr;
  logic [pAddrBits:0]   issued, popped;
  logic                 arm_go, capturing, wr_en, trig_hit, prefill_done, post_done, last_pop;

  logic [1:0]           occ, occ_after;
  logic                 inflight, pop, issue;
  logic [SAMPLE_W-1:0]  buf0, buf1, ram_q;

  // Reset asserts asynchronously, releases after two clock edges.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  // iPreTrig is pAddrBits wide, so it can never exceed pDepth-1.
  assign arm_go       = (state == ST_IDLE) && iArm;
  assign capturing    = (state == ST_PREFILL) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  assign wr_en        = capturing && iSample_Valid;
  assign trig_hit     = (state == ST_WAIT_TRIG) && iSample_Valid && prev_valid &&
                        level_cross(prev, iSample, level, rising_sel);
  assign prefill_done = (state == ST_PREFILL) && iSample_Valid && (cnt == pretrig - pAddrBits'(1));
  assign post_done    = (state == ST_POST) && iSample_Valid && (cnt == pAddrBits'(1));

  assign pop       = oRd_Valid && iRd_Ready;
  assign last_pop  = pop && (popped == WORDS - 1'b1);
  // Occupancy after this cycle's push/pop; a new read is only issued if its
  // data will still fit next cycle even when the consumer stalls.
  assign occ_after = occ + {1'b0, inflight} - {1'b0, pop};
  assign issue     = (state == ST_READOUT) && (issued != WORDS) && (occ_after <= 2'd1);
  assign rd_addr   = trig_addr - pretrig + issued[pAddrBits-1:0];

  assign oBusy      = capturing;
  assign oTriggered = triggered;
  assign oRd_Valid  = (occ != 2'd0);
  assign oRd_Data   = buf0;

  // State register.
  always_ff @(posedge iClk or negedge rst_sync) begin
    if (!rst_sync) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (iArm) state_next = (iPreTrig == '0) ? ST_WAIT_TRIG : ST_PREFILL;
      ST_PREFILL:   if (prefill_done) state_next = ST_WAIT_TRIG;
      ST_WAIT_TRIG: if (trig_hit) state_next = (pretrig == PRE_MAX) ? ST_READOUT : ST_POST;
      ST_POST:      if (post_done) state_next = ST_READOUT;
      ST_READOUT:   if (last_pop) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Capture configuration, write pointer, trigger tracking and readout counters.
  always_ff @(posedge iClk or negedge rst_sync) begin
    if (!rst_sync) begin
      level      <= '0;
      rising_sel <= EDGE_FALLING;
      pretrig    <= '0;
      wr_addr    <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      trig_addr  <= '0;
      triggered  <= 1'b0;
      issued     <= '0;
      popped     <= '0;
    end else begin
      if (arm_go) begin
        level      <= iTrigLevel;
        rising_sel <= iTrigRising;
        pretrig    <= iPreTrig;
        wr_addr    <= '0;
        cnt        <= '0;
        prev_valid <= 1'b0;
        issued     <= '0;
        popped     <= '0;
      end
      if (wr_en) begin
        wr_addr    <= wr_addr + 1'b1;
        prev       <= iSample;
        prev_valid <= 1'b1;
      end
      if ((state == ST_PREFILL) && iSample_Valid) cnt <= cnt + 1'b1;
      if ((state == ST_POST) && iSample_Valid)    cnt <= cnt - 1'b1;
      if (trig_hit) begin
        trig_addr <= wr_addr;
        cnt       <= ~pretrig;
        triggered <= 1'b1;
      end
      if (issue)    issued    <= issued + 1'b1;
      if (pop)      popped    <= popped + 1'b1;
      if (last_pop) triggered <= 1'b0;
    end
  end

  // Two-entry output buffer absorbing the RAM read latency under back-pressure.
  always_ff @(posedge iClk or negedge rst_sync) begin
    if (!rst_sync) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= issue;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= ram_q;
          else             buf1 <= ram_q;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) buf0 <= ram_q;
          else begin
            buf0 <= buf1;
            buf1 <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  scope_capture_ram #(
    .pDepth   (pDepth),
    .pAddrBits(pAddrBits)
  ) u_ram (
    .clk    (iClk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(iSample),
    .rd_en  (issue),
    .rd_addr(rd_addr),
    .rd_data(ram_q)
  );

endmodule

// File: tb/tb_scope_capture.sv
// Randomised bench for scope_capture with a sample-queue reference model.
module tb_scope_capture;

  localparam int DEPTH = 256;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic [7:0] iSample = '0;
  logic       iSample_Valid = 1'b0;
  logic       iArm = 1'b0;
  logic [7:0] iTrigLevel = '0;
  logic       iTrigRising = 1'b0;
  logic [7:0] iPreTrig = '0;
  logic       iRd_Ready = 1'b0;
  logic [7:0] oRd_Data;
  logic       oRd_Valid, oBusy, oTriggered;

  scope_capture #(.pDepth(DEPTH), .pAddrBits(8)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iSample(iSample), .iSample_Valid(iSample_Valid),
    .iArm(iArm), .iTrigLevel(iTrigLevel), .iTrigRising(iTrigRising), .iPreTrig(iPreTrig),
    .iRd_Ready(iRd_Ready), .oRd_Data(oRd_Data), .oRd_Valid(oRd_Valid),
    .oBusy(oBusy), .oTriggered(oTriggered)
  );

  always #5 iClk = ~iClk;

  int passed = 0;
  int total  = 0;
  int tick   = 0;

  always @(posedge iClk) tick <= tick + 1;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference model: every valid sample since arm, trigger index, expected record.
  int sq[$];
  int exp_rec[DEPTH];
  int got_rec[DEPTH];
  int trig_idx;
  bit found, complete;
  int lvl_m, pre_m;
  bit rise_m;

  int gen_kind, gen_base, gen_k;

  function automatic int next_sample();
    int v;
    case (gen_kind)
      0:       v = (gen_base + gen_k) % 256;
      1:       v = 255 - ((gen_base + gen_k) % 256);
      default: v = int'($urandom_range(0, 255));
    endcase
    gen_k++;
    return v;
  endfunction

  task automatic model_push(input int v);
    int n;
    bit hit;
    sq.push_back(v);
    n = sq.size() - 1;
    if (!found && n >= pre_m && n >= 1) begin
      hit = rise_m ? (sq[n-1] < lvl_m && v >= lvl_m) : (sq[n-1] >= lvl_m && v < lvl_m);
      if (hit) begin
        found = 1;
        trig_idx = n;
      end
    end
    if (found && !complete && n == trig_idx + DEPTH - pre_m - 1) begin
      complete = 1;
      for (int j = 0; j < DEPTH; j++) exp_rec[j] = sq[trig_idx - pre_m + j];
    end
  endtask

  // Readout observation state shared with the compare process.
  int   widx = 0;
  bit   mon_en = 0;
  bit   held_v = 0;
  logic [7:0] held_d = '0;
  int   ro_start, first_valid_tick, first_xfer_tick, last_xfer_tick;

  // Compare process: word order/content and hold stability on every readout cycle.
  always @(negedge iClk) begin
    if (mon_en) begin
      if (oRd_Valid && first_valid_tick < 0) first_valid_tick = tick;
      if (held_v) begin
        check("hold_valid", oRd_Valid, 1);
        check("hold_data", oRd_Data, held_d);
      end
      if (oRd_Valid && iRd_Ready) begin
        if (widx < DEPTH) begin
          check($sformatf("word%0d", widx), oRd_Data, exp_rec[widx]);
          got_rec[widx] = oRd_Data;
        end else begin
          check("extra_word_index", widx, DEPTH - 1);
        end
        if (first_xfer_tick < 0) first_xfer_tick = tick;
        last_xfer_tick = tick;
        widx++;
      end
      held_v = oRd_Valid && !iRd_Ready;
      held_d = oRd_Data;
    end
  end

  task automatic capture(input int kind, input int base, input int lvl, input bit rise,
                         input int pre, input bit noise, input int abort_after);
    int cyc;
    gen_kind = kind; gen_base = base; gen_k = 0;
    sq.delete(); found = 0; complete = 0;
    lvl_m = lvl; rise_m = rise; pre_m = pre;
    iArm = 1'b1; iTrigLevel = 8'(lvl); iTrigRising = rise; iPreTrig = 8'(pre);
    @(posedge iClk); #1;
    iArm = 1'b0; iTrigLevel = 8'($urandom); iTrigRising = 1'($urandom); iPreTrig = 8'($urandom);
    cyc = 0;
    while (!complete && cyc < 8000) begin
      check("busy_capture", oBusy, 1);
      check("trig_flag", oTriggered, int'(found));
      if (abort_after > 0 && found && (sq.size() - 1) >= trig_idx + abort_after) break;
      iArm = noise && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) begin
        iSample_Valid = 1'b1;
        iSample = 8'(next_sample());
        model_push(int'(iSample));
      end else begin
        iSample_Valid = 1'b0;
        iSample = 8'($urandom);
      end
      @(posedge iClk); #1;
      cyc++;
    end
    iSample_Valid = 1'b0;
    iArm = 1'b0;
    if (abort_after == 0) begin
      check("capture_done", int'(complete), 1);
      check("busy_fall", oBusy, 0);
      check("trig_at_readout", oTriggered, 1);
    end
  endtask

  task automatic readout(input bit rand_ready, input bit thru);
    int cyc;
    widx = 0; held_v = 0;
    ro_start = tick; first_valid_tick = -1; first_xfer_tick = -1; last_xfer_tick = -1;
    mon_en = 1;
    cyc = 0;
    while (widx < DEPTH && cyc < 4000) begin
      iRd_Ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      iSample_Valid = 1'($urandom_range(0, 1));
      iSample = 8'($urandom);
      @(posedge iClk); #1;
      cyc++;
    end
    check("readout_count", widx, DEPTH);
    iRd_Ready = 1'b1;
    iSample_Valid = 1'b0;
    repeat (4) @(posedge iClk);
    #1;
    check("no_extra_words", widx, DEPTH);
    check("valid_after", oRd_Valid, 0);
    check("busy_after", oBusy, 0);
    check("trig_after", oTriggered, 0);
    mon_en = 0;
    iRd_Ready = 1'b0;
    check("first_valid_latency", int'(first_valid_tick >= 0 && first_valid_tick - ro_start <= 3), 1);
    if (thru) check("throughput_span", last_xfer_tick - first_xfer_tick, DEPTH - 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, oRd_Data, 0);
    check({tag, "_valid"}, oRd_Valid, 0);
    check({tag, "_busy"}, oBusy, 0);
    check({tag, "_trig"}, oTriggered, 0);
  endtask

  initial begin
    int lvl, pre;
    bit ok;

    repeat (3) @(posedge iClk);
    #1;
    check_outputs_zero("reset");
    iRst_n = 1'b1;
    repeat (3) @(posedge iClk);
    #1;

    // Rising ramp, pretrig 64, full-speed readout.
    capture(0, 0, 128, 1'b1, 64, 1'b0, 0);
    readout(1'b0, 1'b1);
    check("t1_word0", got_rec[0], 64);
    check("t1_word64", got_rec[64], 128);
    ok = 1;
    for (int i = 1; i < DEPTH; i++) if (got_rec[i] != (got_rec[i-1] + 1) % 256) ok = 0;
    check("t1_ramp_step", int'(ok), 1);

    // Zero pretrig: the trigger sample leads the record.
    capture(0, 0, 128, 1'b1, 0, 1'b0, 0);
    readout(1'b0, 1'b1);
    check("t2_word0", got_rec[0], 128);

    // Falling edge on a descending ramp, random back-pressure, arm noise.
    capture(1, 0, 100, 1'b0, 32, 1'b1, 0);
    readout(1'b1, 1'b0);
    check("t3_trig_word", got_rec[32], 99);
    check("t3_before_trig", got_rec[31], 100);

    // Maximum pretrig: no post phase at all.
    capture(0, 0, 128, 1'b1, 255, 1'b0, 0);
    readout(1'b1, 1'b0);
    check("t5_last_word", got_rec[255], 128);
    check("t5_word0", got_rec[0], 129);

    // Crossing during prefill must be ignored.
    capture(0, 120, 128, 1'b1, 64, 1'b0, 0);
    check("t6_model_trig_idx", trig_idx, 264);
    readout(1'b0, 1'b1);
    check("t6_trig_word", got_rec[64], 128);
    check("t6_word0", got_rec[0], 64);

    // Random samples and configurations.
    for (int r = 0; r < 3; r++) begin
      lvl = int'($urandom_range(16, 240));
      pre = int'($urandom_range(0, 255));
      capture(2, 0, lvl, 1'($urandom), pre, 1'b1, 0);
      readout(1'b1, 1'b0);
    end

    // Reset in POST aborts, outputs clear immediately, then a fresh record.
    capture(0, 0, 128, 1'b1, 64, 1'b0, 20);
    check("abort_in_post_busy", oBusy, 1);
    #2;
    iRst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (2) @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    check_outputs_zero("post_release");
    capture(0, 37, 200, 1'b1, 100, 1'b1, 0);
    readout(1'b1, 1'b0);
    check("t7_trig_word", got_rec[100], 200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
